// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM states, iterative-op helpers.
package alu_pkg;

    localparam int unsigned OpAdd  = 0;
    localparam int unsigned OpSub  = 1;
    localparam int unsigned OpAnd  = 2;
    localparam int unsigned OpOr   = 3;
    localparam int unsigned OpXor  = 4;
    localparam int unsigned OpSll  = 5;
    localparam int unsigned OpSrl  = 6;
    localparam int unsigned OpSra  = 7;
    localparam int unsigned OpSlt  = 8;
    localparam int unsigned OpSltu = 9;
    localparam int unsigned OpMul  = 10;
    localparam int unsigned OpDivu = 11;
    localparam int unsigned OpRemu = 12;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        IterMul  = 2'd0,
        IterDivu = 2'd1,
        IterRemu = 2'd2
    } iter_kind_t;

    // True for opcodes that take the multi-cycle path.
    function automatic logic is_iterative(input logic [31:0] op);
        return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiplier and restoring divider, one bit per step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  iter_kind_t            kind,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] result_next
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    // x: multiplicand (MUL) / dividend shifting into quotient (DIV)
    // y: multiplier (MUL) / divisor (DIV)
    // acc: product accumulator (MUL) / partial remainder (DIV), one extra bit for the trial subtract
    logic [CntW-1:0]       cnt_q;
    iter_kind_t            kind_q;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [DATA_WIDTH:0]   acc_q, acc_d;
    logic [DATA_WIDTH:0]   rem_shift;
    logic                  rem_ge;

    assign rem_shift = {acc_q[DATA_WIDTH-1:0], x_q[DATA_WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, y_q};
    assign last      = (cnt_q == CntW'(DATA_WIDTH - 1));

    // One multiply or divide step computed from the current state.
    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        if (kind_q == IterMul) begin
            acc_d = {1'b0, acc_q[DATA_WIDTH-1:0] + (y_q[0] ? x_q : '0)};
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else begin
            // Divisor of zero always "fits", giving all-ones quotient and remainder == A.
            acc_d = rem_ge ? (rem_shift - {1'b0, y_q}) : rem_shift;
            x_d   = {x_q[DATA_WIDTH-2:0], rem_ge};
        end
    end

    // Result as it will be once the current step is applied.
    always_comb begin
        result_next = acc_d[DATA_WIDTH-1:0];
        if (kind_q == IterDivu) begin
            result_next = x_d;
        end
    end

    // Operand latch on load, step update while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            kind_q <= IterMul;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
        end else if (load) begin
            cnt_q  <= '0;
            kind_q <= kind;
            x_q    <= a;
            y_q    <= b;
            acc_q  <= '0;
        end else if (step) begin
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU with start/valid handshake and iterative MUL/DIVU/REMU.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [OP_WIDTH-1:0]   ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  Busy_o,
    output logic                  Valid_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic [31:0]           op;
    logic [ShW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] single_res;
    iter_kind_t            iter_kind;
    logic                  core_load, core_step, core_last;
    logic [DATA_WIDTH-1:0] core_result;

    assign op    = 32'(ALU_Operation_i);
    assign shamt = B_i[ShW-1:0];

    // Single-cycle operations; undefined and iterative opcodes give 0 here.
    always_comb begin
        single_res = '0;
        case (op)
            OpAdd:  single_res = A_i + B_i;
            OpSub:  single_res = A_i - B_i;
            OpAnd:  single_res = A_i & B_i;
            OpOr:   single_res = A_i | B_i;
            OpXor:  single_res = A_i ^ B_i;
            OpSll:  single_res = A_i << shamt;
            OpSrl:  single_res = A_i >> shamt;
            OpSra:  single_res = DATA_WIDTH'($signed(A_i) >>> shamt);
            OpSlt:  single_res[0] = $signed(A_i) < $signed(B_i);
            OpSltu: single_res[0] = A_i < B_i;
            default: single_res = '0;
        endcase
    end

    // Map opcode to iterative datapath mode.
    always_comb begin
        case (op)
            OpMul:   iter_kind = IterMul;
            OpDivu:  iter_kind = IterDivu;
            default: iter_kind = IterRemu;
        endcase
    end

    alu_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter_core (
        .clk         (clk),
        .reset       (reset),
        .load        (core_load),
        .step        (core_step),
        .kind        (iter_kind),
        .a           (A_i),
        .b           (B_i),
        .last        (core_last),
        .result_next (core_result)
    );

    // Handshake FSM: Start_i is only honoured in StIdle, so starts during RUN are dropped.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start_i) begin
                    if (is_iterative(op)) begin
                        core_load = 1'b1;
                        state_d   = StRun;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d  = StIdle;
                    result_d = core_result;
                    zero_d   = (core_result == '0);
                    valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign Busy_o       = (state_q == StRun);
    assign Valid_o      = valid_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;

endmodule
